// File: rtl/sym_fir_coe_loader.sv
// Shadow-bank coefficient loader for the reloadable symmetric systolic FIR.
// Streams shadow[HTAP-1] .. shadow[0] into the FIR shift chain, then strobes coe_update.
module sym_fir_coe_loader #(
  parameter int HTAP   = 4,
  parameter int COE_W  = 16,
  parameter int ADDR_W = 2,
  parameter logic signed [COE_W-1:0] COE_INIT [HTAP] = '{16'sd7, 16'sd14, -16'sd138, 16'sd129}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic signed [COE_W-1:0] wr_data,
  input  logic                    commit,
  output logic                    busy,
  output logic                    coe_sload,
  output logic signed [COE_W-1:0] coe_sdata,
  output logic                    coe_update
);

  typedef enum logic [1:0] {INIT, IDLE, SHIFT, UPDATE} state_t;

  state_t                    state;
  logic [ADDR_W-1:0]         idx;
  logic [ADDR_W-1:0]         rd_idx;
  logic                      wr_fire;
  logic                      addr_ok;
  // Sized to the full address space so any wr_addr indexes legally; only [0..HTAP-1] is used.
  logic signed [COE_W-1:0]   shadow [2**ADDR_W];

  assign wr_fire = wr_valid && (state == IDLE);
  assign addr_ok = 32'(wr_addr) < 32'(HTAP);
  assign rd_idx  = ADDR_W'(HTAP - 1) - idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < HTAP; k++) shadow[k] <= COE_INIT[k];
      for (int unsigned k = HTAP; k < 2**ADDR_W; k++) shadow[k] <= '0;
    end else if (wr_fire && addr_ok) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      case (state)
        INIT: begin
          state <= SHIFT;
          idx   <= '0;
        end
        IDLE: begin
          if (commit) begin
            state <= SHIFT;
            idx   <= '0;
          end
        end
        SHIFT: begin
          if (idx == ADDR_W'(HTAP - 1)) state <= UPDATE;
          else                          idx   <= idx + ADDR_W'(1);
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so none depends on an input.
  // INIT is only ever seen right after reset release and reports all-quiet.
  assign wr_ready   = (state == IDLE);
  assign coe_sload  = (state == SHIFT);
  assign coe_update = (state == UPDATE);
  assign busy       = coe_sload || coe_update;
  assign coe_sdata  = coe_sload ? shadow[rd_idx] : '0;

endmodule
